// File: rtl/lsu_stage_pkg.sv
// Shared types for the memory stage: opcodes, access sizes, exception causes, FSM states.
// Pure declarations and combinational helpers; no latency, no flow control.
package lsu_stage_pkg;

    typedef logic [6:0] opcode_t;
    typedef logic [2:0] funct3_t;

    localparam opcode_t OPC_LOAD   = 7'b0000011;
    localparam opcode_t OPC_STORE  = 7'b0100011;
    localparam opcode_t OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        ACC_BYTE  = 2'd0,
        ACC_HALF  = 2'd1,
        ACC_WORD  = 2'd2,
        ACC_DWORD = 2'd3
    } mem_access_t;

    typedef enum logic [3:0] {
        EXC_NONE           = 4'd0,
        EXC_LOAD_MISALIGN  = 4'd4,
        EXC_LOAD_FAULT     = 4'd5,
        EXC_STORE_MISALIGN = 4'd6,
        EXC_STORE_FAULT    = 4'd7
    } exc_cause_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Doubleword only exists on RV64; everything unrecognised falls back to word.
    function automatic mem_access_t get_mem_access_type(input funct3_t f3, input logic rv64);
        case (f3)
            3'b000, 3'b100: get_mem_access_type = ACC_BYTE;
            3'b001, 3'b101: get_mem_access_type = ACC_HALF;
            3'b011:         get_mem_access_type = rv64 ? ACC_DWORD : ACC_WORD;
            default:        get_mem_access_type = ACC_WORD;
        endcase
    endfunction

    function automatic logic get_load_op_sign(input funct3_t f3);
        get_load_op_sign = ~f3[2];
    endfunction

    function automatic logic [2:0] get_align_mask(input mem_access_t size);
        case (size)
            ACC_BYTE: get_align_mask = 3'b000;
            ACC_HALF: get_align_mask = 3'b001;
            ACC_WORD: get_align_mask = 3'b011;
            default:  get_align_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_stage_lane_align.sv
// Byte-lane steering: strobes, store-data shift and load-data extract/extend.
// Purely combinational, zero latency; no flow control.
// Backpressure: none, outputs follow inputs in the same cycle.
module lsu_stage_lane_align
    import lsu_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NB   = XLEN / 8,
    parameter int OFFW = $clog2(NB)
) (
    input  mem_access_t       size,
    input  logic [OFFW-1:0]   offset,
    input  logic              sign,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [XLEN-1:0]   rd_data,
    output logic [NB-1:0]     sel,
    output logic [XLEN-1:0]   wr_shifted,
    output logic [XLEN-1:0]   rd_ext
);

    logic [7:0]      mask8;
    logic [XLEN-1:0] rd_shifted;
    logic [XLEN-1:0] keep;
    logic            msb;
    logic [OFFW+2:0] bit_shift;

    assign bit_shift  = {offset, 3'b000};
    assign sel        = NB'(mask8) << offset;
    assign wr_shifted = wr_data << bit_shift;
    assign rd_shifted = rd_data >> bit_shift;

    always_comb begin
        mask8 = 8'h01;
        keep  = XLEN'(8'hFF);
        msb   = rd_shifted[7];
        case (size)
            ACC_HALF: begin
                mask8 = 8'h03;
                keep  = XLEN'(16'hFFFF);
                msb   = rd_shifted[15];
            end
            ACC_WORD: begin
                mask8 = 8'h0F;
                keep  = XLEN'(32'hFFFF_FFFF);
                msb   = rd_shifted[31];
            end
            ACC_DWORD: begin
                mask8 = 8'hFF;
                keep  = '1;
                msb   = rd_shifted[XLEN-1];
            end
            default: ;
        endcase
    end

    // Bits above the access size are replaced by the sign bit, or zero for unsigned loads.
    assign rd_ext = (rd_shifted & keep) | ({XLEN{sign & msb}} & ~keep);

endmodule

// File: rtl/lsu_stage.sv
// Memory stage: req/ack bus toward the D$, misalign and access-fault exceptions.
// Latency: non-memory/misaligned same cycle; memory op n+2 cycles (n = req-to-ack cycles).
// Backpressure: hazo_stall freezes upstream from acceptance until the DONE cycle.
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int TIMEOUT  = 255,
    parameter int RCNT_LOG = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                src_valid,
    input  opcode_t             src_opcode,
    input  funct3_t             src_funct3,
    input  logic [RCNT_LOG-1:0] src_rd_addr,
    input  logic [XLEN-1:0]     src_rd,
    input  logic [XLEN-1:0]     src_mem_addr,
    input  logic [XLEN-1:0]     src_mem_wr_data,
    output logic                bus_req,
    output logic                bus_we,
    output logic [XLEN-1:0]     bus_addr,
    output logic [XLEN/8-1:0]   bus_sel,
    output logic [XLEN-1:0]     bus_wr_data,
    input  logic                bus_ack,
    input  logic                bus_err,
    input  logic [XLEN-1:0]     bus_rd_data,
    output logic                hazo_stall,
    output logic                dst_valid,
    output logic [RCNT_LOG-1:0] dst_rd_addr,
    output logic [XLEN-1:0]     dst_rd,
    output logic                dst_exc,
    output logic [3:0]          dst_exc_cause
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = $clog2(TIMEOUT + 1);

    lsu_state_t        state_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   result_q;
    logic              exc_q;
    logic [3:0]        cause_q;

    logic              is_load;
    logic              is_store;
    logic              is_mem;
    logic              misaligned;
    mem_access_t       size;
    logic              sign;
    logic [OFFW-1:0]   offset;
    logic [NB-1:0]     lane_sel;
    logic [XLEN-1:0]   lane_wr_data;
    logic [XLEN-1:0]   lane_rd_data;

    assign is_load    = (src_opcode == OPC_LOAD);
    assign is_store   = (src_opcode == OPC_STORE);
    assign is_mem     = is_load | is_store;
    assign size       = get_mem_access_type(src_funct3, XLEN == 64);
    assign sign       = get_load_op_sign(src_funct3);
    assign offset     = src_mem_addr[OFFW-1:0];
    assign misaligned = |(3'(offset) & get_align_mask(size));

    // src_* is frozen by the stall, so the same decode serves both request and response.
    lsu_stage_lane_align #(.XLEN(XLEN)) u_lane_align (
        .size       (size),
        .offset     (offset),
        .sign       (sign),
        .wr_data    (src_mem_wr_data),
        .rd_data    (bus_rd_data),
        .sel        (lane_sel),
        .wr_shifted (lane_wr_data),
        .rd_ext     (lane_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            exc_q       <= 1'b0;
            cause_q     <= '0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_sel     <= '0;
            bus_wr_data <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (src_valid && is_mem && !misaligned) begin
                        bus_req     <= 1'b1;
                        bus_we      <= is_store;
                        bus_addr    <= src_mem_addr & ~XLEN'(NB - 1);
                        bus_sel     <= lane_sel;
                        bus_wr_data <= lane_wr_data;
                        cnt_q       <= '0;
                        result_q    <= '0;
                        exc_q       <= 1'b0;
                        cause_q     <= EXC_NONE;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus_err || (!bus_ack && cnt_q == CW'(TIMEOUT))) begin
                        exc_q   <= 1'b1;
                        cause_q <= is_store ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
                        bus_req <= 1'b0;
                        state_q <= DONE;
                    end else if (bus_ack) begin
                        result_q <= is_load ? lane_rd_data : '0;
                        bus_req  <= 1'b0;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        hazo_stall    = 1'b0;
        dst_valid     = 1'b0;
        dst_rd        = '0;
        dst_exc       = 1'b0;
        dst_exc_cause = EXC_NONE;
        case (state_q)
            IDLE: begin
                if (src_valid && is_mem) begin
                    if (misaligned) begin
                        dst_valid     = 1'b1;
                        dst_exc       = 1'b1;
                        dst_exc_cause = is_store ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
                        dst_rd        = src_mem_addr;
                    end else begin
                        hazo_stall = 1'b1;
                    end
                end else begin
                    dst_valid = src_valid;
                    dst_rd    = src_rd;
                end
            end
            BUSY: hazo_stall = 1'b1;
            DONE: begin
                dst_valid     = 1'b1;
                dst_rd        = result_q;
                dst_exc       = exc_q;
                dst_exc_cause = cause_q;
            end
            default: ;
        endcase
    end

    assign dst_rd_addr = src_rd_addr;

endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: an RV32 instance (TIMEOUT=8) and an RV64 instance.
module tb_lsu_stage;
    import lsu_stage_pkg::*;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]  rda;
        logic [63:0] rd;
        logic        exc;
        logic [3:0]  cause;
        bit          chk_rd;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    logic a_valid; opcode_t a_op; funct3_t a_f3; logic [4:0] a_rda;
    logic [31:0] a_rd, a_addr, a_wd;
    logic a_req, a_we; logic [31:0] a_baddr; logic [3:0] a_sel; logic [31:0] a_bwd;
    logic a_ack, a_err; logic [31:0] a_brd;
    logic a_stall, a_dv; logic [4:0] a_drda; logic [31:0] a_drd; logic a_exc; logic [3:0] a_cause;

    logic b_valid; opcode_t b_op; funct3_t b_f3; logic [4:0] b_rda;
    logic [63:0] b_rd, b_addr, b_wd;
    logic b_req, b_we; logic [63:0] b_baddr; logic [7:0] b_sel; logic [63:0] b_bwd;
    logic b_ack, b_err; logic [63:0] b_brd;
    logic b_stall, b_dv; logic [4:0] b_drda; logic [63:0] b_drd; logic b_exc; logic [3:0] b_cause;

    lsu_stage #(.XLEN(32), .TIMEOUT(TMO), .RCNT_LOG(5)) dut32 (
        .clk(clk), .rst(rst), .src_valid(a_valid), .src_opcode(a_op), .src_funct3(a_f3),
        .src_rd_addr(a_rda), .src_rd(a_rd), .src_mem_addr(a_addr), .src_mem_wr_data(a_wd),
        .bus_req(a_req), .bus_we(a_we), .bus_addr(a_baddr), .bus_sel(a_sel),
        .bus_wr_data(a_bwd), .bus_ack(a_ack), .bus_err(a_err), .bus_rd_data(a_brd),
        .hazo_stall(a_stall), .dst_valid(a_dv), .dst_rd_addr(a_drda), .dst_rd(a_drd),
        .dst_exc(a_exc), .dst_exc_cause(a_cause)
    );

    lsu_stage #(.XLEN(64), .TIMEOUT(TMO), .RCNT_LOG(5)) dut64 (
        .clk(clk), .rst(rst), .src_valid(b_valid), .src_opcode(b_op), .src_funct3(b_f3),
        .src_rd_addr(b_rda), .src_rd(b_rd), .src_mem_addr(b_addr), .src_mem_wr_data(b_wd),
        .bus_req(b_req), .bus_we(b_we), .bus_addr(b_baddr), .bus_sel(b_sel),
        .bus_wr_data(b_bwd), .bus_ack(b_ack), .bus_err(b_err), .bus_rd_data(b_brd),
        .hazo_stall(b_stall), .dst_valid(b_dv), .dst_rd_addr(b_drda), .dst_rd(b_drd),
        .dst_exc(b_exc), .dst_exc_cause(b_cause)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && a_dv) begin
            if (qa.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL m32_unexpected: got dst_valid=1, expected no output");
            end else begin
                ea = qa.pop_front();
                check("m32_rd_addr", 64'(a_drda), 64'(ea.rda));
                if (ea.chk_rd) check("m32_rd", 64'(a_drd), ea.rd);
                check("m32_exc", 64'(a_exc), 64'(ea.exc));
                check("m32_cause", 64'(a_cause), 64'(ea.cause));
            end
        end
        if (!rst && b_dv) begin
            if (qb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL m64_unexpected: got dst_valid=1, expected no output");
            end else begin
                eb = qb.pop_front();
                check("m64_rd_addr", 64'(b_drda), 64'(eb.rda));
                if (eb.chk_rd) check("m64_rd", b_drd, eb.rd);
                check("m64_exc", 64'(b_exc), 64'(eb.exc));
                check("m64_cause", 64'(b_cause), 64'(eb.cause));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pass32(input logic [4:0] rda, input logic [31:0] rd);
        a_valid = 1'b1; a_op = OPC_OP_IMM; a_f3 = 3'b000; a_rda = rda; a_rd = rd;
        qa.push_back('{rda: rda, rd: 64'(rd), exc: 1'b0, cause: 4'd0, chk_rd: 1'b1});
        #1;
        check("pass_stall", 64'(a_stall), 64'd0);
        step();
        a_valid = 1'b0;
    endtask

    task automatic misal32(input logic st, input funct3_t f3, input logic [4:0] rda,
                           input logic [31:0] addr, input logic [3:0] cause);
        a_valid = 1'b1; a_op = st ? OPC_STORE : OPC_LOAD; a_f3 = f3; a_rda = rda; a_addr = addr;
        qa.push_back('{rda: rda, rd: 64'(addr), exc: 1'b1, cause: cause, chk_rd: 1'b1});
        #1;
        check("misal_stall", 64'(a_stall), 64'd0);
        step();
        check("misal_no_req", 64'(a_req), 64'd0);
        a_valid = 1'b0;
    endtask

    // resp: 0 = ack, 1 = err, 2 = err and ack together
    task automatic mem32(input logic st, input funct3_t f3, input logic [4:0] rda,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdd,
                         input int nwait, input int resp, input logic [3:0] esel,
                         input logic [31:0] ewd, input logic [31:0] erd,
                         input logic eexc, input logic [3:0] ecause, input bit chkrd);
        a_valid = 1'b1; a_op = st ? OPC_STORE : OPC_LOAD; a_f3 = f3; a_rda = rda;
        a_addr = addr; a_wd = wd; a_rd = 32'h0;
        qa.push_back('{rda: rda, rd: 64'(erd), exc: eexc, cause: ecause, chk_rd: chkrd});
        #1;
        check("m32_stall_accept", 64'(a_stall), 64'd1);
        step();
        for (int i = 0; i < nwait; i++) begin
            check("m32_stall_busy", 64'(a_stall), 64'd1);
            check("m32_req_held", 64'(a_req), 64'd1);
            step();
        end
        check("m32_req", 64'(a_req), 64'd1);
        check("m32_we", 64'(a_we), 64'(st));
        check("m32_addr", 64'(a_baddr), 64'(addr & ~32'h3));
        check("m32_sel", 64'(a_sel), 64'(esel));
        if (st) check("m32_wdata", 64'(a_bwd), 64'(ewd));
        a_ack = (resp != 1); a_err = (resp != 0); a_brd = rdd;
        step();
        a_ack = 1'b0; a_err = 1'b0;
        check("m32_req_drop", 64'(a_req), 64'd0);
        check("m32_stall_done", 64'(a_stall), 64'd0);
        step();
        a_valid = 1'b0;
    endtask

    task automatic mem64(input logic st, input funct3_t f3, input logic [4:0] rda,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rdd,
                         input logic [7:0] esel, input logic [63:0] ewd, input logic [63:0] erd);
        b_valid = 1'b1; b_op = st ? OPC_STORE : OPC_LOAD; b_f3 = f3; b_rda = rda;
        b_addr = addr; b_wd = wd; b_rd = 64'h0;
        qb.push_back('{rda: rda, rd: erd, exc: 1'b0, cause: 4'd0, chk_rd: 1'b1});
        #1;
        check("m64_stall_accept", 64'(b_stall), 64'd1);
        step();
        check("m64_req", 64'(b_req), 64'd1);
        check("m64_we", 64'(b_we), 64'(st));
        check("m64_addr", b_baddr, addr & ~64'h7);
        check("m64_sel", 64'(b_sel), 64'(esel));
        if (st) check("m64_wdata", b_bwd, ewd);
        b_ack = 1'b1; b_brd = rdd;
        step();
        b_ack = 1'b0;
        check("m64_req_drop", 64'(b_req), 64'd0);
        step();
        b_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  req_cycles;
        bit  done;
        a_valid = 0; a_op = OPC_OP_IMM; a_f3 = 0; a_rda = 0; a_rd = 0; a_addr = 0; a_wd = 0;
        a_ack = 0; a_err = 0; a_brd = 0;
        b_valid = 0; b_op = OPC_OP_IMM; b_f3 = 0; b_rda = 0; b_rd = 0; b_addr = 0; b_wd = 0;
        b_ack = 0; b_err = 0; b_brd = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 64'(a_req), 64'd0);
        check("rst_stall", 64'(a_stall), 64'd0);
        check("rst_dv", 64'(a_dv), 64'd0);
        check("rst_sel", 64'(a_sel), 64'd0);
        check("rst_addr", 64'(a_baddr), 64'd0);
        check("rst_req64", 64'(b_req), 64'd0);
        rst = 1'b0;
        step();

        pass32(5'd5, 32'h1234_5678);
        mem32(0, 3'b000, 5'd1, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0, 4'b1000, 32'h0, 32'hFFFF_FF80, 0, 4'd0, 1);
        mem32(1, 3'b001, 5'd2, 32'h2002, 32'h0000_BEEF, 32'h0, 3, 0, 4'b1100, 32'hBEEF_0000, 32'h0, 0, 4'd0, 1);
        mem32(0, 3'b101, 5'd3, 32'h1002, 32'h0, 32'hABCD_1234, 1, 0, 4'b1100, 32'h0, 32'h0000_ABCD, 0, 4'd0, 1);
        mem32(0, 3'b100, 5'd4, 32'h1001, 32'h0, 32'h0000_9A00, 0, 0, 4'b0010, 32'h0, 32'h0000_009A, 0, 4'd0, 1);
        misal32(0, 3'b010, 5'd6, 32'h3001, 4'd4);
        misal32(1, 3'b001, 5'd7, 32'h2001, 4'd6);

        // LW that never gets an ack
        a_valid = 1'b1; a_op = OPC_LOAD; a_f3 = 3'b010; a_rda = 5'd8; a_addr = 32'h3000;
        qa.push_back('{rda: 5'd8, rd: 64'd0, exc: 1'b1, cause: 4'd5, chk_rd: 1'b0});
        step();
        req_cycles = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (a_req) begin
                req_cycles++;
                step();
            end else begin
                done = 1;
            end
        end
        check("tmo_req_dropped", 64'(done), 64'd1);
        check("tmo_req_cycles_in_range", 64'(req_cycles >= TMO && req_cycles <= TMO + 1), 64'd1);
        check("tmo_stall_done", 64'(a_stall), 64'd0);
        step();
        a_valid = 1'b0;
        a_ack = 1'b1; a_brd = 32'hFFFF_FFFF;
        step();
        a_ack = 1'b0;
        check("spurious_ack_req", 64'(a_req), 64'd0);
        check("spurious_ack_dv", 64'(a_dv), 64'd0);
        step();

        mem32(1, 3'b010, 5'd9, 32'h5004, 32'h1357_9BDF, 32'h0, 0, 2, 4'b1111, 32'h1357_9BDF, 32'h0, 1, 4'd7, 1);

        // reset while a LW is outstanding
        a_valid = 1'b1; a_op = OPC_LOAD; a_f3 = 3'b010; a_rda = 5'd10; a_addr = 32'h6000;
        step();
        check("rstmid_req_before", 64'(a_req), 64'd1);
        rst = 1'b1; a_valid = 1'b0;
        step();
        check("rstmid_req_after", 64'(a_req), 64'd0);
        check("rstmid_stall", 64'(a_stall), 64'd0);
        rst = 1'b0; a_ack = 1'b1;
        step();
        a_ack = 1'b0;
        check("rstmid_late_ack_req", 64'(a_req), 64'd0);
        check("rstmid_late_ack_dv", 64'(a_dv), 64'd0);
        mem32(0, 3'b000, 5'd11, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0, 4'b1000, 32'h0, 32'hFFFF_FF80, 0, 4'd0, 1);

        mem64(0, 3'b110, 5'd1, 64'h4004, 64'h0, 64'h8000_0001_DEAD_BEEF, 8'hF0, 64'h0, 64'h0000_0000_8000_0001);
        mem64(0, 3'b010, 5'd4, 64'h4000, 64'h0, 64'h0000_0000_8000_0000, 8'h0F, 64'h0, 64'hFFFF_FFFF_8000_0000);
        mem64(0, 3'b011, 5'd2, 64'h4008, 64'h0, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 64'h1122_3344_5566_7788);
        mem64(1, 3'b011, 5'd3, 64'h4010, 64'hCAFE_BABE_0123_4567, 64'h0, 8'hFF, 64'hCAFE_BABE_0123_4567, 64'h0);

        repeat (2) step();
        check("q32_drained", 64'(qa.size()), 64'd0);
        check("q64_drained", 64'(qb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
